pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch-stage sequencer for the single-cycle RISC-V core.
- Sits directly upstream of the program ROM: owns the PC register and drives the ROM byte address every cycle.
- Selects the next PC from sequential, branch or JALR sources, and supports stall and halt.
- Detects misaligned or out-of-range fetch targets and traps into a terminal FAULT state.

Parameters:
- DATA_WIDTH, 32, width of PC, targets and address outputs
- RESET_VECTOR, 32'h00400000, PC value loaded on reset (text segment base)
- MEMORY_DEPTH, 32, number of instruction words in the program ROM; used for range checking

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable_i  input  1  1 = PC may advance this cycle; 0 = stall (PC holds)
- branch_taken_i  input  1  conditional branch or JAL resolved taken
- branch_target_i  input  DATA_WIDTH  PC-relative target from the adder
- jalr_i  input  1  JALR in execute
- jalr_target_i  input  DATA_WIDTH  rs1+imm; bit 0 is cleared internally
- halt_i  input  1  halt request (ECALL/EBREAK decode)
- pc_o  output  DATA_WIDTH  current PC; connects to the ROM address input
- pc_plus4_o  output  DATA_WIDTH  pc_o+4, link value for JAL/JALR
- fetch_valid_o  output  1  instruction at pc_o is to be executed this cycle
- halted_o  output  1  unit is in HALT
- fault_o  output  1  unit is in FAULT
- fault_pc_o  output  DATA_WIDTH  offending target address captured on entry to FAULT

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-fault):
  - State = BOOT; pc_o = RESET_VECTOR.
  - fetch_valid_o = 0, halted_o = 0, fault_o = 0, fault_pc_o = 0.
- State encoding: BOOT, RUN, HALT, FAULT (2-bit registered).
- BOOT:
  - Exactly one cycle after reset release; PC holds and fetch_valid_o = 0.
  - Next state is RUN unconditionally.
  - This absorbs the ROM settle time after reset.
- RUN:
  - fetch_valid_o = enable_i. Updates occur on a rising edge with enable_i = 1.
  - Next-PC priority: halt_i > jalr_i > branch_taken_i > sequential.
  - halt_i: PC holds; next state HALT.
  - jalr_i: target = {jalr_target_i[DATA_WIDTH-1:1], 1'b0}.
  - branch_taken_i: target = branch_target_i.
  - Otherwise: target = pc_o + 4, modulo 2^DATA_WIDTH; wrap is legal arithmetic but is caught by the range check.
  - Target check: the target is legal iff target[1:0] == 0 AND RESET_VECTOR <= target < RESET_VECTOR + 4*MEMORY_DEPTH (unsigned compare, DATA_WIDTH+1 bits, no overflow).
  - Legal target: pc_o <= target.
  - Illegal target: PC holds, fault_pc_o <= target, next state FAULT.
  - enable_i = 0: PC, state and fault_pc_o all hold; halt_i, jalr_i and branch_taken_i are ignored.
- HALT:
  - PC frozen; fetch_valid_o = 0; halted_o = 1.
  - Exit only via reset.
- FAULT:
  - PC frozen; fetch_valid_o = 0; fault_o = 1; fault_pc_o stable.
  - Exit only via reset.
- pc_plus4_o = pc_o + 4, combinational, valid in every state.
- Outputs halted_o and fault_o are decoded from the state register (glitch-free).
- Latency: a target presented in cycle N appears on pc_o after the rising edge ending cycle N.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output instret_o (DATA_WIDTH): counts cycles with fetch_valid_o = 1, wrapping at 2^DATA_WIDTH.
  - Adds output stall_cnt_o (DATA_WIDTH): counts RUN cycles with enable_i = 0.
  - Both counters clear on reset, freeze in HALT and FAULT, and are reported at the rising edge.
- Not defined: both ports are absent, no counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset and boot:
  - Stimulus: assert reset, release, enable_i = 1, no controls, 5 cycles.
  - Response: pc_o = 0x00400000 for 2 cycles (fetch_valid_o = 0 in BOOT), then 0x00400004, 0x00400008, 0x0040000C.
- Priority:
  - Stimulus: in RUN at pc 0x00400010, assert jalr_i (target 0x00400021) together with branch_taken_i (0x00400040).
  - Response: next pc_o = 0x00400020.
- Stall:
  - Stimulus: enable_i = 0 for 3 cycles at pc 0x00400008 while branch_taken_i = 1.
  - Response: pc_o stays 0x00400008 and fetch_valid_o = 0; after release the branch is taken.
- Faults:
  - Stimulus: branch_target_i = 0x00400006.
  - Response: fault_o = 1, fault_pc_o = 0x00400006, pc_o frozen.
  - Stimulus: sequential run off the last word (pc 0x0040007C, MEMORY_DEPTH = 32).
  - Response: FAULT with fault_pc_o = 0x00400080.
- Halt then async reset:
  - Stimulus: halt_i at 0x00400014; later, reset pulsed asynchronously mid-cycle.
  - Response: halted_o = 1 and pc holds; on the reset pulse, all outputs return to reset values immediately, without waiting for a clock edge.
- FETCH_PERF_CNT_EN:
  - Stimulus: 10 enabled RUN cycles with 2 stall cycles, then halt.
  - Response: instret_o = 10, stall_cnt_o = 2, both frozen after halt.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer: owns the PC, picks the next fetch address and traps bad targets.
// Optional performance counters (instret_o, stall_cnt_o) are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h00400000,
  parameter int                    MEMORY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jalr_i,
  input  logic [DATA_WIDTH-1:0] jalr_target_i,
  input  logic                  halt_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fetch_valid_o,
  output logic                  halted_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] fault_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] instret_o,
  output logic [DATA_WIDTH-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // One extra bit so the upper bound of the ROM window cannot overflow.
  localparam logic [DATA_WIDTH:0] C_LO = {1'b0, RESET_VECTOR};
  localparam logic [DATA_WIDTH:0] C_HI = C_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fault_pc;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] w_next_fault_pc;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH:0]   w_target_ext;
  logic                  w_legal;

  always_comb begin
    w_target = r_pc + DATA_WIDTH'(4);
    if (jalr_i) begin
      w_target = jalr_target_i & ~(DATA_WIDTH'(1));
    end else if (branch_taken_i) begin
      w_target = branch_target_i;
    end
  end

  assign w_target_ext = {1'b0, w_target};
  assign w_legal      = (w_target[1:0] == 2'b00) && (w_target_ext >= C_LO) && (w_target_ext < C_HI);

  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_fault_pc = r_fault_pc;
    case (r_state)
      BOOT: w_next_state = RUN;
      RUN: begin
        if (enable_i) begin
          if (halt_i) begin
            w_next_state = HALT;
          end else if (w_legal) begin
            w_next_pc = w_target;
          end else begin
            w_next_fault_pc = w_target;
            w_next_state    = FAULT;
          end
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_fault_pc <= w_next_fault_pc;
    end
  end

  assign pc_o          = r_pc;
  assign pc_plus4_o    = r_pc + DATA_WIDTH'(4);
  assign fetch_valid_o = (r_state == RUN) && enable_i;
  assign halted_o      = (r_state == HALT);
  assign fault_o       = (r_state == FAULT);
  assign fault_pc_o    = r_fault_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] r_instret;
  logic [DATA_WIDTH-1:0] r_stall_cnt;

  // Counters only move in RUN, so they freeze naturally in HALT and FAULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret   <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == RUN) begin
      if (enable_i) begin
        r_instret <= r_instret + DATA_WIDTH'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt + DATA_WIDTH'(1);
      end
    end
  end

  assign instret_o   = r_instret;
  assign stall_cnt_o = r_stall_cnt;
`else
  // Default build carries no counter state.
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, async-reset cases,
// then randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam int          W     = 32;
  localparam logic [31:0] RV    = 32'h00400000;
  localparam int          DEPTH = 32;

  localparam int PH_BOOT  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_HALT  = 2;
  localparam int PH_FAULT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enableI = 1'b0;
  logic          branchTakenI = 1'b0;
  logic [W-1:0]  branchTargetI = '0;
  logic          jalrI = 1'b0;
  logic [W-1:0]  jalrTargetI = '0;
  logic          haltI = 1'b0;
  logic [W-1:0]  pcO;
  logic [W-1:0]  pcPlus4O;
  logic          fetchValidO;
  logic          haltedO;
  logic          faultO;
  logic [W-1:0]  faultPcO;
`ifdef FETCH_PERF_CNT_EN
  logic [W-1:0]  instretO;
  logic [W-1:0]  stallCntO;
`endif

  pc_fetch_unit #(
    .DATA_WIDTH  (W),
    .RESET_VECTOR(RV),
    .MEMORY_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enableI),
    .branch_taken_i (branchTakenI),
    .branch_target_i(branchTargetI),
    .jalr_i         (jalrI),
    .jalr_target_i  (jalrTargetI),
    .halt_i         (haltI),
    .pc_o           (pcO),
    .pc_plus4_o     (pcPlus4O),
    .fetch_valid_o  (fetchValidO),
    .halted_o       (haltedO),
    .fault_o        (faultO),
    .fault_pc_o     (faultPcO)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instret_o      (instretO),
    .stall_cnt_o    (stallCntO)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rstBefore;
    bit          en;
    bit          br;
    logic [31:0] bt;
    bit          jr;
    logic [31:0] jt;
    bit          h;
    logic [31:0] expPc;
    bit          expValid;
    bit          expHalted;
    bit          expFault;
    logic [31:0] expFaultPc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  int          mPhase;
  logic [31:0] mPc;
  logic [31:0] mFaultPc;
  logic [31:0] mInstret;
  logic [31:0] mStall;

  function automatic vec_t mk(bit rstBefore, bit en, bit br, logic [31:0] bt, bit jr, logic [31:0] jt,
                              bit h, logic [31:0] expPc, bit expValid, bit expHalted, bit expFault,
                              logic [31:0] expFaultPc);
    vec_t v;
    v.rstBefore = rstBefore; v.en = en; v.br = br; v.bt = bt; v.jr = jr; v.jt = jt; v.h = h;
    v.expPc = expPc; v.expValid = expValid; v.expHalted = expHalted; v.expFault = expFault;
    v.expFaultPc = expFaultPc;
    return v;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: the fetch rules written as plain arithmetic on the model's PC.
  task automatic modelReset();
    mPhase = PH_BOOT; mPc = RV; mFaultPc = 0; mInstret = 0; mStall = 0;
  endtask

  task automatic modelStep();
    longint tgt;
    bit     legal;
    if (mPhase == PH_BOOT) begin
      mPhase = PH_RUN;
    end else if (mPhase == PH_RUN) begin
      if (!enableI) begin
        mStall = mStall + 1;
      end else begin
        mInstret = mInstret + 1;
        if (haltI) begin
          mPhase = PH_HALT;
        end else begin
          if (jalrI)             tgt = longint'(jalrTargetI) - (longint'(jalrTargetI) % 2);
          else if (branchTakenI) tgt = longint'(branchTargetI);
          else                   tgt = (longint'(mPc) + 4) % 64'h1_0000_0000;
          legal = (tgt % 4 == 0) && (tgt >= longint'(RV)) && (tgt < longint'(RV) + 4 * DEPTH);
          if (legal) mPc = tgt[31:0];
          else begin
            mFaultPc = tgt[31:0];
            mPhase   = PH_FAULT;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(logic [31:0] expPc, bit expValid, bit expHalted, bit expFault,
                             logic [31:0] expFaultPc);
    checkVal("pc_o", pcO, expPc);
    checkVal("pc_plus4_o", pcPlus4O, expPc + 32'd4);
    checkVal("fetch_valid_o", 32'(fetchValidO), 32'(expValid));
    checkVal("halted_o", 32'(haltedO), 32'(expHalted));
    checkVal("fault_o", 32'(faultO), 32'(expFault));
    checkVal("fault_pc_o", faultPcO, expFaultPc);
`ifdef FETCH_PERF_CNT_EN
    checkVal("instret_o", instretO, mInstret);
    checkVal("stall_cnt_o", stallCntO, mStall);
`endif
  endtask

  task automatic driveInputs(bit en, bit br, logic [31:0] bt, bit jr, logic [31:0] jt, bit h);
    enableI = en; branchTakenI = br; branchTargetI = bt; jalrI = jr; jalrTargetI = jt; haltI = h;
  endtask

  // Called at a falling edge; leaves reset released at the next falling edge.
  task automatic pulseReset();
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(vec_t v);
    if (v.rstBefore) pulseReset();
    driveInputs(v.en, v.br, v.bt, v.jr, v.jt, v.h);
    #1;
    checkOutput(v.expPc, v.expValid, v.expHalted, v.expFault, v.expFaultPc);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  // Reset asserted between clock edges must take effect without waiting for a clock.
  task automatic midCycleReset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput(RV, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randTarget();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)       return RV + 32'($urandom_range(0, 4 * DEPTH - 1));
    else if (r < 12) return (r % 2 == 0) ? RV - 32'd4 : RV + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
    else             return RV + 32'(4 * $urandom_range(0, DEPTH - 1));
  endfunction

  task automatic applyRandom();
    bit          en, br, jr, h;
    logic [31:0] bt, jt;
    en = ($urandom_range(0, 9) < 8);
    br = ($urandom_range(0, 9) < 3);
    jr = ($urandom_range(0, 9) < 2);
    h  = ($urandom_range(0, 99) < 2);
    bt = randTarget();
    jt = randTarget() | 32'($urandom_range(0, 1));
    driveInputs(en, br, bt, jr, jt, h);
    #1;
    checkOutput(mPc, (mPhase == PH_RUN) && en, mPhase == PH_HALT, mPhase == PH_FAULT, mFaultPc);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    //           rst en br bt            jr jt            h  expPc         v  hl f  expFaultPc
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400004, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h00400040, 0, 32'h0,        0, 32'h00400008, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h00400040, 0, 32'h0,        1, 32'h00400008, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h00400040, 1, 32'h00400003, 0, 32'h00400008, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400040, 0, 32'h0,        0, 32'h00400008, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400010, 0, 32'h0,        0, 32'h00400040, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400040, 1, 32'h00400021, 0, 32'h00400010, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400014, 0, 32'h0,        0, 32'h00400020, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h00400030, 1, 32'h00400014, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400030, 0, 32'h0,        0, 32'h00400014, 0, 1, 0, 32'h0));
    foreach (vecs[i]) applyStimulus(vecs[i]);
    midCycleReset();

    vecs.delete();
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00400006, 0, 32'h0,        0, 32'h00400000, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 1, 32'h00400006));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h00400020, 0, 32'h00400000, 0, 0, 1, 32'h00400006));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h0040007C, 0, 32'h0,        0, 32'h00400000, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0040007C, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0040007C, 0, 0, 1, 32'h00400080));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h003FFFFD, 0, 32'h00400000, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400000, 0, 0, 1, 32'h003FFFFC));
    foreach (vecs[i]) applyStimulus(vecs[i]);
    midCycleReset();

    for (int n = 0; n < 800; n++) begin
      if ((mPhase == PH_HALT || mPhase == PH_FAULT) && $urandom_range(0, 3) == 0) pulseReset();
      applyRandom();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
